// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+rw, one data byte (write or read), STOP.
// SCL is generated from a quarter-period tick; each bit period spans four ticks.
module i2c_master_ctrl #(
    parameter int unsigned QDIV = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int unsigned QW = 10;
    localparam int unsigned SW = 16;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_ADDR     = 3'd2;
    localparam logic [2:0] S_ADDR_ACK = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;
    localparam logic [2:0] S_DATA_ACK = 3'd5;
    localparam logic [2:0] S_STOP     = 3'd6;

    logic [2:0]    state, state_n;
    logic [1:0]    phase, phase_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [SW-1:0] sreg, sreg_n;
    logic          rw_q, rw_n;
    logic          busy_n, done_n, ack_err_n;
    logic [7:0]    rdata_n;
    logic          scl_n, sda_oe_n;
    logic          tick;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            phase   <= 2'd0;
            qcnt    <= '0;
            bitcnt  <= 3'd0;
            sreg    <= '0;
            rw_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= 8'h00;
            scl     <= 1'b1;
            sda_oe  <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            qcnt    <= qcnt_n;
            bitcnt  <= bitcnt_n;
            sreg    <= sreg_n;
            rw_q    <= rw_n;
            busy    <= busy_n;
            done    <= done_n;
            ack_err <= ack_err_n;
            rdata   <= rdata_n;
            scl     <= scl_n;
            sda_oe  <= sda_oe_n;
        end
    end

    // Next-state, sequencing and bus-level computation
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        qcnt_n    = qcnt;
        bitcnt_n  = bitcnt;
        sreg_n    = sreg;
        rw_n      = rw_q;
        busy_n    = busy;
        done_n    = 1'b0;
        ack_err_n = ack_err;
        rdata_n   = rdata;
        scl_n     = 1'b1;
        sda_oe_n  = 1'b0;
        tick      = busy && (qcnt == QW'(QDIV - 1));

        if (state == S_IDLE) begin
            if (start) begin
                state_n   = S_START;
                phase_n   = 2'd0;
                qcnt_n    = '0;
                bitcnt_n  = 3'd0;
                sreg_n    = {addr, rw, wdata};
                rw_n      = rw;
                busy_n    = 1'b1;
                ack_err_n = 1'b0;
            end
        end else begin
            qcnt_n = tick ? '0 : qcnt + QW'(1);
            if (tick) begin
                phase_n = phase + 2'd1;
                // Sample point at the end of the SCL-high half
                if (phase == 2'd2) begin
                    case (state)
                        S_ADDR_ACK: if (sda_i) ack_err_n = 1'b1;
                        S_DATA_ACK: if (!rw_q && sda_i) ack_err_n = 1'b1;
                        S_DATA:     if (rw_q) rdata_n = {rdata[6:0], sda_i};
                        default:    ;
                    endcase
                end
                // Bit period boundary: advance bit/state
                if (phase == 2'd3) begin
                    case (state)
                        S_START: state_n = S_ADDR;
                        S_ADDR, S_DATA: begin
                            sreg_n = {sreg[SW-2:0], 1'b0};
                            if (bitcnt == 3'd7) begin
                                bitcnt_n = 3'd0;
                                state_n  = (state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                            end else begin
                                bitcnt_n = bitcnt + 3'd1;
                            end
                        end
                        S_ADDR_ACK: state_n = ack_err ? S_STOP : S_DATA;
                        S_DATA_ACK: state_n = S_STOP;
                        S_STOP: begin
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            qcnt_n  = '0;
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
        end

        // Line levels for the upcoming cycle, derived from the next state/phase
        case (state_n)
            S_START: begin
                scl_n    = (phase_n != 2'd3);
                sda_oe_n = (phase_n >= 2'd2);
            end
            S_ADDR: begin
                scl_n    = (phase_n == 2'd1) || (phase_n == 2'd2);
                sda_oe_n = ~sreg_n[SW-1];
            end
            S_DATA: begin
                scl_n    = (phase_n == 2'd1) || (phase_n == 2'd2);
                sda_oe_n = rw_n ? 1'b0 : ~sreg_n[SW-1];
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_n    = (phase_n == 2'd1) || (phase_n == 2'd2);
                sda_oe_n = 1'b0;
            end
            S_STOP: begin
                scl_n    = (phase_n != 2'd0);
                sda_oe_n = (phase_n < 2'd2);
            end
            default: begin
                scl_n    = 1'b1;
                sda_oe_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: an I2C target model watching the bus, plus
// transaction-level expectations (latency, captured bytes, ack_err, rdata).
module tb_i2c_master_ctrl;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, ack_err, scl, sda_oe, sda_i;
    logic [7:0] rdata;

    // Target configuration
    logic       cfg_nack_addr = 1'b0;
    logic       cfg_nack_data = 1'b0;
    logic [7:0] cfg_rbyte = 8'h00;

    // Target state (owned by the target process)
    logic       slave_sda = 1'b1;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, line;
    int         bitn = 0;
    int         n_start = 0, n_stop = 0;
    logic [7:0] cap_addr = 8'h00, cap_data = 8'h00;
    logic       ninth_rd = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mdl_rdata = 8'h00;

    assign sda_i = ~sda_oe & slave_sda;

    i2c_master_ctrl #(.QDIV(Q)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw),
        .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
        .rdata(rdata), .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // I2C target: detects START/STOP, captures bits on SCL rise, drives on SCL fall
    always @(negedge clk) begin
        if (!rst_n) begin
            slave_sda = 1'b1;
            prev_scl  = 1'b1;
            prev_sda  = 1'b1;
            bitn      = 0;
        end else begin
            line = sda_i;
            if (prev_scl && scl && (line != prev_sda)) begin
                if (!line) begin
                    n_start++;
                    bitn = 0;
                    cap_addr = 8'h00;
                    cap_data = 8'h00;
                end else begin
                    n_stop++;
                end
            end
            if (!prev_scl && scl) begin
                bitn++;
                if (bitn <= 8) cap_addr = {cap_addr[6:0], line};
                else if (bitn >= 10 && bitn <= 17) cap_data = {cap_data[6:0], line};
                else if (bitn == 18) ninth_rd = line;
            end
            if (prev_scl && !scl && bitn > 0) begin
                if (bitn == 8)
                    slave_sda = cfg_nack_addr;
                else if (bitn >= 9 && bitn <= 16)
                    slave_sda = (!cfg_nack_addr && cap_addr[0]) ? cfg_rbyte[16 - bitn] : 1'b1;
                else if (bitn == 17)
                    slave_sda = cap_addr[0] ? 1'b1 : cfg_nack_data;
                else
                    slave_sda = 1'b1;
            end
            prev_scl = scl;
            prev_sda = line;
        end
    end

    // One transaction; inject = cycle to pulse a stray start, late = start on the done clock
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic na, input logic nd, input logic [7:0] rb,
                           input int inject, input bit late);
        int cnt, exp_lat, s0, p0;
        logic exp_err;
        exp_lat = na ? 44 * Q : 80 * Q;
        exp_err = na | (~r & nd);
        if (r && !na) mdl_rdata = rb;
        s0 = n_start;
        p0 = n_stop;
        cfg_nack_addr = na;
        cfg_nack_data = nd;
        cfg_rbyte = rb;
        @(negedge clk);
        addr = a; rw = r; wdata = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
        chk("busy_on", 32'(busy), 32'd1);
        cnt = 0;
        while (cnt < 1000) begin
            if (done) break;
            start = (cnt == inject) || (late && cnt == exp_lat - 1);
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        chk("latency", 32'(cnt), 32'(exp_lat));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("ack_err", 32'(ack_err), 32'(exp_err));
        chk("rdata", 32'(rdata), 32'(mdl_rdata));
        chk("addr_byte", 32'(cap_addr), 32'({a, r}));
        if (!na && !r) chk("wdata_byte", 32'(cap_data), 32'(wd));
        if (!na && r) chk("master_nack", 32'(ninth_rd), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_scl", 32'(scl), 32'd1);
        chk("idle_sda_oe", 32'(sda_oe), 32'd0);
        chk("n_start", 32'(n_start - s0), 32'd1);
        chk("n_stop", 32'(n_stop - p0), 32'd1);
    endtask

    // Start a write, then assert reset mid-transaction
    task automatic run_reset(input int rst_at);
        int cnt;
        cfg_nack_addr = 1'b0;
        cfg_nack_data = 1'b0;
        @(negedge clk);
        addr = 7'h11; rw = 1'b0; wdata = 8'hC3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (cnt < rst_at - 1) begin
            @(negedge clk);
            cnt++;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        mdl_rdata = 8'h00;
        #1;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [6:0] ra;
        logic [7:0] rw8, rb8;
        logic       rr, rna, rnd;
        repeat (3) @(negedge clk);
        chk("reset_scl", 32'(scl), 32'd1);
        chk("reset_sda_oe", 32'(sda_oe), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, -1, 1'b0);
        run_txn(7'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 8'h5A, -1, 1'b0);
        run_txn(7'h2B, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00, -1, 1'b0);
        run_txn(7'h41, 1'b0, 8'h3E, 1'b0, 1'b1, 8'h00, -1, 1'b0);
        run_txn(7'h12, 1'b0, 8'h9C, 1'b0, 1'b0, 8'h00, 36, 1'b0);
        run_txn(7'h6D, 1'b1, 8'h00, 1'b0, 1'b0, 8'hC7, -1, 1'b1);
        run_reset(150);
        run_txn(7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra  = 7'($urandom);
            rr  = 1'($urandom);
            rw8 = 8'($urandom);
            rb8 = 8'($urandom);
            rna = ($urandom_range(0, 3) == 0);
            rnd = ($urandom_range(0, 3) == 0);
            run_txn(ra, rr, rw8, rna, rnd, rb8, (i == 3) ? int'($urandom_range(5, 200)) : -1, (i == 5));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 The block SHALL have parameter QDIV, default 5: system clocks per SCL quarter-period (legal range 2..1023).
REQ-002 The block SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1: one-clock request pulse to run one transaction.
REQ-005 The block SHALL have port addr, input, 7: 7-bit target address, sampled on accepted start.
REQ-006 The block SHALL have port rw, input, 1: 0 = write, 1 = read; sampled on accepted start.
REQ-007 The block SHALL have port wdata, input, 8: write byte, sampled on accepted start.
REQ-008 The block SHALL have port busy, output, 1: high from the clock after accepted start until done.
REQ-009 The block SHALL have port done, output, 1: one-clock pulse at transaction end.
REQ-010 The block SHALL have port ack_err, output, 1: NACK seen in the last transaction; valid with done, held until next accepted start.
REQ-011 The block SHALL have port rdata, output, 8: byte read, valid with done when rw=1, held until next read.
REQ-012 The block SHALL have port scl, output, 1: SCL line level.
REQ-013 The block SHALL have port sda_oe, output, 1: 1 = pull SDA low, 0 = release.
REQ-014 The block SHALL have port sda_i, input, 1: sampled SDA line level.

Function
REQ-015 start SHALL be accepted only in IDLE; start while busy=1 SHALL be ignored with no effect on outputs or latched inputs.
REQ-016 Quarter counter SHALL count 0..QDIV-1 while busy, clear to 0 on accept, and emit a tick on the clock where it equals QDIV-1 (first tick QDIV clocks after accept).
REQ-017 Each bit period SHALL be 4 ticks, phases 0..3: ph0 scl=0 and drive SDA; ph1 scl=1; ph2 scl=1 and sample sda_i; ph3 scl=0.
REQ-018 States SHALL be IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP; transitions only on the tick ending ph3.
REQ-019 START: sda_oe=0 and scl=1 for ph0-ph1; sda_oe=1 from ph2; scl=0 at ph3; then ADDR.
REQ-020 ADDR: 8 bit periods sending {addr, rw} MSB first; sda_oe = ~bit; then ADDR_ACK.
REQ-021 ADDR_ACK: sda_oe=0; sda_i sampled at ph2; sda_i=1 sets ack_err and goes to STOP; 0 goes to DATA.
REQ-022 DATA write: 8 bits of wdata MSB first as in ADDR; DATA_ACK samples sda_i at ph2; 1 sets ack_err; then STOP.
REQ-023 DATA read: sda_oe=0; sda_i shifted into rdata MSB first at each ph2; DATA_ACK keeps sda_oe=0 (master NACK); then STOP.
REQ-024 STOP: ph0 scl=0 and sda_oe=1; ph1 scl=1; ph2 sda_oe=0; ph3 scl stays 1; then IDLE, done=1 for that one clock, busy=0 the same clock.
REQ-025 Full transaction SHALL last 20 bit periods = 80*QDIV clocks from accept to done; an address NACK SHALL cut it to 11 bit periods = 44*QDIV clocks.
REQ-026 In IDLE: scl=1, sda_oe=0, done=0.
REQ-027 start on the same clock as done SHALL be ignored (block is not yet in IDLE); start the next clock SHALL be accepted.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counters 0, scl=1, sda_oe=0, busy=0, done=0, ack_err=0, rdata=8'h00, including mid-transaction; no STOP is generated.

Verification
REQ-029 Write, QDIV=5: addr=7'h50, rw=0, wdata=8'hA5, target ACKs -> SDA bits 0xA0 then 0xA5, done 400 clocks after accept, ack_err=0.
REQ-030 Read, QDIV=5: addr=7'h3C, rw=1, target drives 8'h5A -> rdata=8'h5A, master NACK on ninth bit, ack_err=0.
REQ-031 Address NACK: sda_i held 1 -> no DATA bits, STOP follows, done at 220 clocks, ack_err=1.
REQ-032 start pulsed at accept+37 while busy -> ignored; the transaction and its latched addr/wdata are unchanged.
REQ-033 rst_n low at accept+150 -> same-clock scl=1, sda_oe=0, busy=0; a fresh start after release completes normally.
REQ-034 Bus protocol check: SDA changes only while scl=0, except the START fall and STOP rise while scl=1.
